detector_responder: RTL and testbench

Detector-side responder for the experiment trigger/ready handshake. It receives the output trigger from the experiment sequencer and answers on `detector_ready`. After a fixed response latency it drops `detector_ready` for a programmable readout time, raises it again, and pulses `frame_done`. It sits on the board as a detector emulator for bench and bring-up runs, and can stand in front of a real detector front end. It also counts accepted frames and triggers missed while busy.

---
 rtl/detector_responder_pkg.sv | 13 +
 rtl/detector_responder_if.sv | 24 ++
 rtl/detector_responder_sat_counter.sv | 17 +
 rtl/detector_responder.sv | 86 ++++++++
 tb/tb_detector_responder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/detector_responder_pkg.sv
// sync_pkg: shared state encoding and defaults for the detector responder
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATENCY = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } responder_state_t;

    localparam int DEFAULT_READOUT_CYCLES = 200;

endpackage

// File: rtl/detector_responder_if.sv
// detector_responder_if: trigger/ready handshake plus status between sequencer and detector
interface detector_responder_if #(
    parameter int COUNT_W = 16
);

    logic               trigger_in;
    logic [31:0]        readout_cycles;
    logic               detector_ready;
    logic               frame_done;
    logic [COUNT_W-1:0] frame_count;
    logic [COUNT_W-1:0] missed_count;
    logic [1:0]         responder_state;

    modport master (
        output trigger_in, readout_cycles,
        input  detector_ready, frame_done, frame_count, missed_count, responder_state
    );

    modport slave (
        input  trigger_in, readout_cycles,
        output detector_ready, frame_done, frame_count, missed_count, responder_state
    );

endinterface

// File: rtl/detector_responder_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    // count events, holding at the maximum value
    always_ff @(posedge clock) begin
        if (reset) value <= '0;
        else if (inc && value != '1) value <= value + W'(1);
    end

endmodule

// File: rtl/detector_responder.sv
// detector_responder: detector emulator answering sequencer triggers with a ready/busy handshake
module detector_responder
    import sync_pkg::*;
#(
    parameter int RESPONSE_DELAY = 5,
    parameter int COUNT_W        = 16
) (
    input logic                  clock,
    input logic                  reset,
    detector_responder_if.slave  bus
);

    localparam logic [1:0]  S_IDLE    = IDLE;
    localparam logic [1:0]  S_LATENCY = LATENCY;
    localparam logic [1:0]  S_BUSY    = BUSY;
    localparam logic [1:0]  S_DONE    = DONE;
    localparam logic [31:0] LAT_LAST  = 32'(RESPONSE_DELAY - 1);

    logic [1:0]  state;
    logic [31:0] cnt;
    logic [31:0] busy_len;
    logic        trig_d;
    logic        frame_done_q;
    logic        edge_seen;
    logic        busy_end;

    assign edge_seen = bus.trigger_in & ~trig_d;
    assign busy_end  = (state == S_BUSY) && (cnt == busy_len - 32'd1);

    assign bus.detector_ready  = state != S_BUSY;
    assign bus.frame_done      = frame_done_q;
    assign bus.responder_state = state;

    // handshake FSM: accept an edge, wait the response latency, stay busy, then re-arm on trigger low
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy_len     <= '0;
            trig_d       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            trig_d       <= bus.trigger_in;
            frame_done_q <= busy_end;
            case (state)
                S_IDLE: begin
                    if (edge_seen) begin
                        busy_len <= (bus.readout_cycles == 32'd0) ? 32'd1 : bus.readout_cycles;
                        cnt      <= '0;
                        state    <= (RESPONSE_DELAY == 0) ? S_BUSY : S_LATENCY;
                    end
                end
                S_LATENCY: begin
                    if (cnt == LAT_LAST) begin
                        cnt   <= '0;
                        state <= S_BUSY;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_BUSY: begin
                    if (busy_end) state <= S_DONE;
                    else cnt <= cnt + 32'd1;
                end
                default: begin
                    if (!bus.trigger_in) state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(COUNT_W)) u_frames (
        .clock (clock),
        .reset (reset),
        .inc   (busy_end),
        .value (bus.frame_count)
    );

    sat_counter #(.W(COUNT_W)) u_missed (
        .clock (clock),
        .reset (reset),
        .inc   (edge_seen && state != S_IDLE),
        .value (bus.missed_count)
    );

endmodule

// File: tb/tb_detector_responder.sv
// tb_detector_responder: directed checks of the trigger/ready handshake on two configurations
module tb_detector_responder;
    import sync_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   first_low, last_low, low_n, done_at, done_n, done_st;

    always #5 clk = ~clk;

    detector_responder_if #(.COUNT_W(16)) if0 ();
    detector_responder_if #(.COUNT_W(4))  if1 ();

    detector_responder #(.RESPONSE_DELAY(5), .COUNT_W(16)) dut0 (.clock(clk), .reset(rst), .bus(if0.slave));
    detector_responder #(.RESPONSE_DELAY(0), .COUNT_W(4))  dut1 (.clock(clk), .reset(rst), .bus(if1.slave));

    // observe one dut for a number of cycles; sample k is taken 1 time unit after the k-th edge
    task automatic watch(input int sel, input int cycles, input int fall_k, input int rise_k,
                         input int ro_k, input logic [31:0] ro_val);
        logic rdy, fd;
        logic [1:0] st;
        first_low = -1; last_low = -1; low_n = 0; done_at = -1; done_n = 0; done_st = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk); #1;
            rdy = sel ? if1.detector_ready : if0.detector_ready;
            fd  = sel ? if1.frame_done : if0.frame_done;
            st  = sel ? if1.responder_state : if0.responder_state;
            if (!rdy) begin
                if (first_low < 0) first_low = k;
                last_low = k;
                low_n++;
            end
            if (fd) begin
                if (done_at < 0) done_at = k;
                done_n++;
            end
            if (st == 2'd3) done_st++;
            if (k == fall_k) begin if (sel) if1.trigger_in = 1'b0; else if0.trigger_in = 1'b0; end
            if (k == rise_k) begin if (sel) if1.trigger_in = 1'b1; else if0.trigger_in = 1'b1; end
            if (k == ro_k) begin if (sel) if1.readout_cycles = ro_val; else if0.readout_cycles = ro_val; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (if0.detector_ready !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b want=1", if0.detector_ready); end
        total++; if (if0.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b want=0", if0.frame_done); end
        total++; if (if0.frame_count !== 16'd0) begin bad++; $display("FAIL reset_frames0 got=%0d want=0", if0.frame_count); end
        total++; if (if0.missed_count !== 16'd0) begin bad++; $display("FAIL reset_missed0 got=%0d want=0", if0.missed_count); end
        total++; if (if0.responder_state !== 2'd0) begin bad++; $display("FAIL reset_state0 got=%0d want=0", if0.responder_state); end
        total++; if (if1.detector_ready !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", if1.detector_ready); end
        total++; if (if1.frame_count !== 4'd0) begin bad++; $display("FAIL reset_frames1 got=%0d want=0", if1.frame_count); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        if0.readout_cycles = 32'(DEFAULT_READOUT_CYCLES);
        if0.trigger_in = 1'b1;
        watch(0, 230, 220, 0, 0, 32'd0);
        total++; if (first_low !== 6) begin bad++; $display("FAIL basic_first_low got=%0d want=6", first_low); end
        total++; if (last_low !== 205) begin bad++; $display("FAIL basic_last_low got=%0d want=205", last_low); end
        total++; if (low_n !== 200) begin bad++; $display("FAIL basic_low_n got=%0d want=200", low_n); end
        total++; if (done_at !== 206) begin bad++; $display("FAIL basic_done_at got=%0d want=206", done_at); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_n got=%0d want=1", done_n); end
        total++; if (if0.frame_count !== 16'd1) begin bad++; $display("FAIL basic_frames got=%0d want=1", if0.frame_count); end
        total++; if (if0.missed_count !== 16'd0) begin bad++; $display("FAIL basic_missed got=%0d want=0", if0.missed_count); end
        total++; if (if0.responder_state !== 2'd0) begin bad++; $display("FAIL basic_state_end got=%0d want=0", if0.responder_state); end
    endtask

    task automatic test_zero_delay_len();
        if1.readout_cycles = 32'd0;
        if1.trigger_in = 1'b1;
        watch(1, 6, 3, 0, 0, 32'd0);
        total++; if (first_low !== 1) begin bad++; $display("FAIL zero_first_low got=%0d want=1", first_low); end
        total++; if (low_n !== 1) begin bad++; $display("FAIL zero_low_n got=%0d want=1", low_n); end
        total++; if (done_at !== 2) begin bad++; $display("FAIL zero_done_at got=%0d want=2", done_at); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL zero_done_n got=%0d want=1", done_n); end
        total++; if (if1.frame_count !== 4'd1) begin bad++; $display("FAIL zero_frames got=%0d want=1", if1.frame_count); end
    endtask

    task automatic test_held_trigger();
        if0.readout_cycles = 32'd20;
        if0.trigger_in = 1'b1;
        watch(0, 1000, 0, 0, 0, 32'd0);
        total++; if (done_n !== 1) begin bad++; $display("FAIL held_done_n got=%0d want=1", done_n); end
        total++; if (done_at !== 26) begin bad++; $display("FAIL held_done_at got=%0d want=26", done_at); end
        total++; if (done_st !== 975) begin bad++; $display("FAIL held_done_cycles got=%0d want=975", done_st); end
        total++; if (if0.frame_count !== 16'd2) begin bad++; $display("FAIL held_frames got=%0d want=2", if0.frame_count); end
        total++; if (if0.missed_count !== 16'd0) begin bad++; $display("FAIL held_missed got=%0d want=0", if0.missed_count); end
        if0.trigger_in = 1'b0;
        @(posedge clk); #1;
        total++; if (if0.responder_state !== 2'd0) begin bad++; $display("FAIL held_rearm got=%0d want=0", if0.responder_state); end
    endtask

    task automatic test_trigger_during_busy();
        if0.readout_cycles = 32'd30;
        if0.trigger_in = 1'b1;
        watch(0, 60, 3, 15, 8, 32'd5);
        total++; if (low_n !== 30) begin bad++; $display("FAIL busytrig_low_n got=%0d want=30", low_n); end
        total++; if (last_low !== 35) begin bad++; $display("FAIL busytrig_last_low got=%0d want=35", last_low); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL busytrig_done_n got=%0d want=1", done_n); end
        total++; if (if0.missed_count !== 16'd1) begin bad++; $display("FAIL busytrig_missed got=%0d want=1", if0.missed_count); end
        total++; if (if0.frame_count !== 16'd3) begin bad++; $display("FAIL busytrig_frames got=%0d want=3", if0.frame_count); end
        if0.trigger_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_busy();
        if0.readout_cycles = 32'(DEFAULT_READOUT_CYCLES);
        if0.trigger_in = 1'b1;
        watch(0, 55, 0, 0, 0, 32'd0);
        total++; if (if0.responder_state !== 2'd2) begin bad++; $display("FAIL midrst_pre_state got=%0d want=2", if0.responder_state); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (if0.detector_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", if0.detector_ready); end
        total++; if (if0.responder_state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", if0.responder_state); end
        total++; if (if0.frame_count !== 16'd0) begin bad++; $display("FAIL midrst_frames got=%0d want=0", if0.frame_count); end
        total++; if (if0.missed_count !== 16'd0) begin bad++; $display("FAIL midrst_missed got=%0d want=0", if0.missed_count); end
        rst = 1'b0;
        watch(0, 210, 0, 0, 0, 32'd0);
        total++; if (first_low !== 6) begin bad++; $display("FAIL midrst_first_low got=%0d want=6", first_low); end
        total++; if (low_n !== 200) begin bad++; $display("FAIL midrst_low_n got=%0d want=200", low_n); end
        total++; if (done_at !== 206) begin bad++; $display("FAIL midrst_done_at got=%0d want=206", done_at); end
        total++; if (if0.frame_count !== 16'd1) begin bad++; $display("FAIL midrst_frames_after got=%0d want=1", if0.frame_count); end
        if0.trigger_in = 1'b0;
    endtask

    task automatic test_saturation();
        if1.readout_cycles = 32'd1;
        for (int f = 1; f <= 20; f++) begin
            if1.trigger_in = 1'b1;
            @(posedge clk); #1;
            if1.trigger_in = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            if (f == 14) begin
                total++; if (if1.frame_count !== 4'd14) begin bad++; $display("FAIL sat_frames14 got=%0d want=14", if1.frame_count); end
            end
        end
        total++; if (if1.frame_count !== 4'd15) begin bad++; $display("FAIL sat_frames20 got=%0d want=15", if1.frame_count); end
        total++; if (if1.missed_count !== 4'd0) begin bad++; $display("FAIL sat_missed got=%0d want=0", if1.missed_count); end
    endtask

    initial begin
        rst = 1'b1;
        if0.trigger_in = 1'b0;
        if0.readout_cycles = 32'd0;
        if1.trigger_in = 1'b0;
        if1.readout_cycles = 32'd0;
        test_reset();
        test_basic_frame();
        test_zero_delay_len();
        test_held_trigger();
        test_trigger_during_busy();
        test_reset_mid_busy();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
